// File: rtl/pbvi_pkg.sv
// Shared sizes, types and helpers for the PBVI policy-select block.
package pbvi_pkg;

   localparam int unsigned N_POINT = 16;
   localparam int unsigned N_STATE = 2;
   localparam int unsigned W       = 16;
   localparam int unsigned Q_SHIFT = 15;
   localparam int unsigned ACC_W   = 34;
   localparam int unsigned PROD_W  = 2 * W + 1;

   localparam int SAT_MAX = (2 ** (W - 1)) - 1;
   localparam int SAT_MIN = -(2 ** (W - 1));

   typedef logic [W-1:0]            word_t;
   typedef logic [1:0]              action_t;
   typedef logic signed [ACC_W-1:0] acc_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Rescale a Q(8.8 x 1.15) accumulator back to Q8.8, clamped to the word range.
   function automatic word_t sat_word(input acc_t acc);
      acc_t sh;
      sh = acc >>> Q_SHIFT;
      if (sh > acc_t'(SAT_MAX))      sat_word = word_t'(SAT_MAX);
      else if (sh < acc_t'(SAT_MIN)) sat_word = word_t'(SAT_MIN);
      else                           sat_word = word_t'(sh);
   endfunction

endpackage

// File: rtl/pbvi_dot2.sv
// Two-term dot product: signed Q8.8 alpha against unsigned Q1.15 belief, full precision.
module pbvi_dot2
   import pbvi_pkg::*;
(
   input  logic [W-1:0]            a0,
   input  logic [W-1:0]            a1,
   input  logic [W-1:0]            b0,
   input  logic [W-1:0]            b1,
   output logic signed [ACC_W-1:0] dot_c
);

   logic signed [PROD_W-1:0] p0;
   logic signed [PROD_W-1:0] p1;

   // Belief is zero-extended so the product stays a signed 16x17 multiply.
   assign p0    = PROD_W'($signed(a0)) * PROD_W'($signed({1'b0, b0}));
   assign p1    = PROD_W'($signed(a1)) * PROD_W'($signed({1'b0, b1}));
   assign dot_c = acc_t'(p0) + acc_t'(p1);

endmodule

// File: rtl/pbvi_policy_select.sv
// Scans all alpha vectors against a captured belief, one per cycle, and reports the arg-max.
module pbvi_policy_select
   import pbvi_pkg::*;
#(
   parameter int unsigned N_POINT = pbvi_pkg::N_POINT,
   parameter int unsigned N_STATE = pbvi_pkg::N_STATE,
   parameter int unsigned W       = pbvi_pkg::W
)(
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic                                  policy_ok,
   input  logic [N_STATE-1:0][W-1:0]             belief,
   input  logic [N_POINT-1:0][N_STATE-1:0][W-1:0] alpha,
   input  logic [N_POINT-1:0][1:0]               point_action,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  err,
   output logic [1:0]                            action,
   output logic [3:0]                            best_idx,
   output logic [W-1:0]                          best_value
);

   localparam int unsigned CNT_W = (N_POINT > 1) ? $clog2(N_POINT) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_POINT - 1);

   state_t                    state_q, state_n;
   logic [N_STATE-1:0][W-1:0] belief_q, belief_n;
   acc_t                      max_q, max_n;
   logic [CNT_W-1:0]          idx_q, idx_n;
   logic [CNT_W-1:0]          win_idx_q, win_idx_n;
   action_t                   win_act_q, win_act_n;
   logic                      lost_q, lost_n;

   logic                      busy_n, done_n, err_n;
   action_t                   action_n;
   logic [3:0]                best_idx_n;
   logic [W-1:0]              best_value_n;

   acc_t                      dot_c;
   logic                      take_c;
   acc_t                      cand_max_c;
   logic [CNT_W-1:0]          cand_idx_c;
   action_t                   cand_act_c;

   pbvi_dot2 u_dot2 (
      .a0    (alpha[idx_q][0]),
      .a1    (alpha[idx_q][1]),
      .b0    (belief_q[0]),
      .b1    (belief_q[1]),
      .dot_c (dot_c)
   );

   // Running arg-max including the vector under evaluation; strict compare keeps lowest index on ties.
   always_comb begin
      take_c     = (idx_q == '0) || (dot_c > max_q);
      cand_max_c = take_c ? dot_c : max_q;
      cand_idx_c = take_c ? idx_q : win_idx_q;
      cand_act_c = take_c ? action_t'(point_action[idx_q]) : win_act_q;
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n      = state_q;
      belief_n     = belief_q;
      max_n        = max_q;
      idx_n        = idx_q;
      win_idx_n    = win_idx_q;
      win_act_n    = win_act_q;
      lost_n       = lost_q;
      err_n        = err;
      action_n     = action;
      best_idx_n   = best_idx;
      best_value_n = best_value;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (policy_ok) begin
                  belief_n  = belief;
                  max_n     = '0;
                  idx_n     = '0;
                  win_idx_n = '0;
                  win_act_n = '0;
                  lost_n    = 1'b0;
                  state_n   = SCAN;
               end else begin
                  err_n        = 1'b1;
                  action_n     = '0;
                  best_idx_n   = '0;
                  best_value_n = '0;
                  state_n      = DONE;
               end
            end
         end
         SCAN: begin
            max_n     = cand_max_c;
            win_idx_n = cand_idx_c;
            win_act_n = cand_act_c;
            lost_n    = lost_q | ~policy_ok;
            if (idx_q == LAST_IDX) begin
               err_n        = lost_q | ~policy_ok;
               action_n     = cand_act_c;
               best_idx_n   = 4'(cand_idx_c);
               best_value_n = W'(sat_word(cand_max_c));
               state_n      = DONE;
            end else begin
               idx_n = idx_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n == SCAN);
      done_n = (state_n == DONE);
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         belief_q   <= '0;
         max_q      <= '0;
         idx_q      <= '0;
         win_idx_q  <= '0;
         win_act_q  <= '0;
         lost_q     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         action     <= '0;
         best_idx   <= '0;
         best_value <= '0;
      end else begin
         state_q    <= state_n;
         belief_q   <= belief_n;
         max_q      <= max_n;
         idx_q      <= idx_n;
         win_idx_q  <= win_idx_n;
         win_act_q  <= win_act_n;
         lost_q     <= lost_n;
         busy       <= busy_n;
         done       <= done_n;
         err        <= err_n;
         action     <= action_n;
         best_idx   <= best_idx_n;
         best_value <= best_value_n;
      end
   end

endmodule
